smem_output_writer: RTL and testbench
=====================================

SMEM_OUTPUT_WRITER -- requirements
Module: smem_output_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, line buffer depth (power of 2, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, host byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port output_request  input  1  result stage wants to stream.
REQ-006 SHALL have port output_permit  output  1  grant to result stage.
REQ-007 SHALL have port output_data  input  512  result line (header or two mem slots).
REQ-008 SHALL have port output_valid  input  1  output_data valid this cycle.
REQ-009 SHALL have port output_finish  input  1  result stage has emitted all lines (level).
REQ-010 SHALL have port stall  output  1  backpressure to result stage.
REQ-011 SHALL have port base_addr  input  ADDR_W  host destination base, byte address.
REQ-012 SHALL have port wr_valid / wr_addr / wr_data  output  1 / ADDR_W / 512  host write request.
REQ-013 SHALL have port wr_ready  input  1  host accepts write when wr_valid & wr_ready.
REQ-014 SHALL have port line_count  output  16  lines written to host.
REQ-015 SHALL have port done  output  1  all lines written; sticky until reset.
REQ-016 SHALL have port overflow  output  1  sticky error: push while FIFO full.

Function
REQ-017 SHALL implement FSM IDLE, GRANT, DRAIN, DONE.
REQ-018 IDLE: on output_request=1, SHALL capture base_addr, go GRANT; output_permit=1 from the next cycle, held through GRANT and DRAIN.
REQ-019 GRANT: each cycle with output_valid=1 SHALL push output_data into the FIFO, irrespective of stall.
REQ-020 GRANT -> DRAIN when output_finish=1; a valid line in that same cycle SHALL still be pushed.
REQ-021 DRAIN -> DONE when FIFO empty and no write pending; done=1 registered on DONE entry.
REQ-022 DONE SHALL hold (permit=1, wr_valid=0) until reset; request ignored.
REQ-023 stall SHALL be registered, =1 when occupancy >= FIFO_DEPTH-2 (covers one in-flight registered valid), else 0.
REQ-024 FIFO head SHALL drive wr_data with wr_valid=1 whenever FIFO non-empty; wr_data/wr_addr stable while wr_valid & !wr_ready.
REQ-025 wr_addr SHALL equal captured base + 64*line_count, modulo 2^ADDR_W (wraps silently).
REQ-026 Each accepted write SHALL pop FIFO and increment line_count; line_count saturates at 0xFFFF, address continues advancing.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged; push on empty FIFO SHALL first appear on wr_valid the next cycle (1-cycle latency).
REQ-028 Push with FIFO full and no pop SHALL drop the line and set overflow=1; a pop in the same cycle frees space and the push is accepted.
REQ-029 output_valid outside GRANT SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, FIFO empty, output_permit=0, stall=0, wr_valid=0, wr_addr=0, wr_data=0, line_count=0, done=0, overflow=0.
REQ-031 Reset mid-stream SHALL discard buffered lines; no write issued until a new request.

Configuration
REQ-032 Macro SMEM_OUTWR_PERF_EN defined: SHALL add output stall_cycles (32 bits), count of cycles with stall=1 or (wr_valid & !wr_ready), saturating, reset 0.
REQ-033 Macro undefined: port stall_cycles and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 Request, 5 valid lines, finish, wr_ready=1, base 0x1000 -> writes at 0x1000..0x1100 step 0x40, line_count=5, done=1.
REQ-035 wr_ready=0 for 40 cycles while 20 lines arrive (upstream honours stall) -> stall rises at occupancy 14, no line lost, overflow=0, 20 ordered writes after release.
REQ-036 Base 0xFFFF_FFC0, 3 lines -> addresses 0xFFFF_FFC0, 0x0000_0000, 0x0000_0040.
REQ-037 Upstream ignores stall, wr_ready=0, 18 valid lines -> 16 stored, overflow=1, line_count=16 after release.
REQ-038 reset_n low after 3 of 8 lines written -> all outputs at reset values immediately; fresh request restarts at line_count=0.
REQ-039 Finish asserted in same cycle as last valid line -> line written, done=1 only after its wr_ready handshake.

Source files
------------

// File: rtl/smem_output_writer.sv
// rtl/smem_output_writer.sv - buffers 512-bit result lines and streams them to host memory.
// Optional SMEM_OUTWR_PERF_EN adds the stall_cycles counter output.
module smem_output_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              output_request,
    output logic              output_permit,
    input  logic [511:0]      output_data,
    input  logic              output_valid,
    input  logic              output_finish,
    output logic              stall,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [511:0]      wr_data,
    input  logic              wr_ready,
    output logic [15:0]       line_count,
    output logic              done,
    output logic              overflow
`ifdef SMEM_OUTWR_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [511:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_line_count;
    logic               r_stall;
    logic               r_done;
    logic               r_overflow;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_wr_valid;

    assign w_wr_valid  = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = w_wr_valid && wr_ready;
    assign w_push_req  = (r_state == S_GRANT) && output_valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign output_permit = (r_state != S_IDLE);
    assign stall         = r_stall;
    assign wr_valid      = w_wr_valid;
    assign wr_addr       = r_addr;
    assign wr_data       = w_wr_valid ? r_mem[r_rptr] : '0;
    assign line_count    = r_line_count;
    assign done          = r_done;
    assign overflow      = r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (output_request) w_state_nxt = S_GRANT;
            S_GRANT: if (output_finish) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_count == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_line_count <= '0;
            r_stall      <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // Threshold leaves room for one more line already in flight upstream.
            r_stall <= (w_count_nxt >= CNT_W'(FIFO_DEPTH - 2));
            if (w_state_nxt == S_DONE) r_done <= 1'b1;
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (r_state == S_IDLE && output_request) begin
                r_addr <= base_addr;
            end else if (w_pop) begin
                r_addr <= r_addr + ADDR_W'(64);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                if (r_line_count != 16'hFFFF) r_line_count <= r_line_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= output_data;
    end

`ifdef SMEM_OUTWR_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if ((r_stall || (w_wr_valid && !wr_ready)) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_smem_output_writer.sv
// tb/tb_smem_output_writer.sv - directed self-checking bench for smem_output_writer.
module tb_smem_output_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         output_request;
    logic         output_permit;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_finish;
    logic         stall;
    logic [31:0]  base_addr;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic [15:0]  line_count;
    logic         done;
    logic         overflow;
`ifdef SMEM_OUTWR_PERF_EN
    logic [31:0]  stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0]  addr_q[$];
    logic [511:0] data_q[$];

    always #5 clk = ~clk;

    smem_output_writer #(.FIFO_DEPTH(16), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .output_request(output_request), .output_permit(output_permit),
        .output_data(output_data), .output_valid(output_valid),
        .output_finish(output_finish), .stall(stall), .base_addr(base_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .line_count(line_count), .done(done),
        .overflow(overflow)
`ifdef SMEM_OUTWR_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [511:0] mkdata(input int n);
        return {16{32'hA500_0000 + 32'(n)}};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; a handshake seen now completes at the next rising edge.
    task automatic cycle();
        #1;
        if (wr_valid && wr_ready) begin
            addr_q.push_back(wr_addr);
            data_q.push_back(wr_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        output_request = 1'b0; output_valid = 1'b0; output_finish = 1'b0;
        output_data = '0; base_addr = '0; wr_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        addr_q.delete(); data_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " permit"},     output_permit, 1'b0);
        check({tag, " stall"},      stall, 1'b0);
        check({tag, " wr_valid"},   wr_valid, 1'b0);
        check({tag, " wr_addr"},    wr_addr, 32'h0);
        check({tag, " wr_data"},    wr_data, 512'h0);
        check({tag, " line_count"}, line_count, 16'h0);
        check({tag, " done"},       done, 1'b0);
        check({tag, " overflow"},   overflow, 1'b0);
    endtask

    task automatic start(input logic [31:0] base);
        base_addr = base;
        output_request = 1'b1;
        cycle();
        output_request = 1'b0;
        check("permit after request", output_permit, 1'b1);
    endtask

    task automatic push_lines(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            output_valid = 1'b1;
            output_data = mkdata(first + i);
            cycle();
        end
        output_valid = 1'b0;
    endtask

    task automatic finish_wait(input string tag);
        output_finish = 1'b1;
        for (int i = 0; i < 300 && !done; i++) cycle();
        check({tag, " done"}, done, 1'b1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base, input int n);
        logic [31:0] a;
        check({tag, " write count"}, addr_q.size(), n);
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            a = base + 32'(64 * i);
            check({tag, " addr"}, addr_q[i], a);
            check({tag, " data"}, data_q[i], mkdata(i));
        end
    endtask

    initial begin
        int sent;
        int stall_at;

        // Basic stream: 5 lines at base 0x1000, host always ready
        do_reset();
        check_reset_vals("reset");
        output_valid = 1'b1; output_data = mkdata(77);
        cycle(); cycle();
        output_valid = 1'b0;
        check("idle valid ignored", wr_valid, 1'b0);
        wr_ready = 1'b1;
        start(32'h1000);
        output_valid = 1'b1; output_data = mkdata(0);
        cycle();
        check("first line latency wr_valid", wr_valid, 1'b1);
        check("first line latency wr_data", wr_data, mkdata(0));
        push_lines(1, 4);
        finish_wait("basic");
        check_writes("basic", 32'h1000, 5);
        check("basic line_count", line_count, 16'd5);
        check("basic overflow", overflow, 1'b0);
        output_request = 1'b1;
        cycle(); cycle();
        output_request = 1'b0;
        check("done sticky", done, 1'b1);
        check("done permit", output_permit, 1'b1);
        check("done wr_valid", wr_valid, 1'b0);

        // Backpressure: upstream honours stall while host stalls 40 cycles
        do_reset();
        start(32'h2000);
        sent = 0; stall_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (stall && stall_at < 0) stall_at = sent;
            if (!stall && sent < 20) begin
                output_valid = 1'b1; output_data = mkdata(sent); sent++;
            end else output_valid = 1'b0;
            cycle();
        end
        output_valid = 1'b0;
        check("stall threshold occupancy", stall_at, 14);
        check("lines held during stall", sent, 14);
        check("stall level", stall, 1'b1);
        check("no write while not ready", addr_q.size(), 0);
        wr_ready = 1'b1;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            if (!stall) begin
                output_valid = 1'b1; output_data = mkdata(sent); sent++;
            end else output_valid = 1'b0;
            cycle();
        end
        output_valid = 1'b0;
        finish_wait("backpressure");
        check_writes("backpressure", 32'h2000, 20);
        check("backpressure overflow", overflow, 1'b0);
        check("backpressure line_count", line_count, 16'd20);

        // Address wrap
        do_reset();
        wr_ready = 1'b1;
        start(32'hFFFF_FFC0);
        push_lines(0, 3);
        finish_wait("wrap");
        check_writes("wrap", 32'hFFFF_FFC0, 3);

        // Overflow: upstream ignores stall
        do_reset();
        start(32'h4000);
        push_lines(0, 18);
        check("overflow flag", overflow, 1'b1);
        check("overflow head data", wr_data, mkdata(0));
        wr_ready = 1'b1;
        finish_wait("overflow");
        check_writes("overflow", 32'h4000, 16);
        check("overflow line_count", line_count, 16'd16);
        check("overflow sticky", overflow, 1'b1);

        // Reset mid-stream
        do_reset();
        start(32'h5000);
        push_lines(0, 8);
        wr_ready = 1'b1;
        cycle(); cycle(); cycle();
        wr_ready = 1'b0;
        check("midstream line_count", line_count, 16'd3);
        check("midstream writes", addr_q.size(), 3);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        addr_q.delete(); data_q.delete();
        wr_ready = 1'b1;
        repeat (5) cycle();
        check("no write after reset", addr_q.size(), 0);
        check("no permit after reset", output_permit, 1'b0);
        start(32'h6000);
        push_lines(0, 2);
        finish_wait("restart");
        check_writes("restart", 32'h6000, 2);
        check("restart line_count", line_count, 16'd2);

        // Finish in same cycle as last line; done waits for its handshake
        do_reset();
        start(32'h7000);
        output_valid = 1'b1; output_data = mkdata(0);
        cycle();
        output_data = mkdata(1); output_finish = 1'b1;
        cycle();
        output_valid = 1'b1; output_data = mkdata(99);
        cycle(); cycle();
        output_valid = 1'b0;
        repeat (3) cycle();
        check("last line pending done", done, 1'b0);
        check("last line pending wr_valid", wr_valid, 1'b1);
        wr_ready = 1'b1;
        cycle();
        check("after first handshake done", done, 1'b0);
        cycle();
        check("after last handshake wr_valid", wr_valid, 1'b0);
        finish_wait("same-cycle finish");
        check_writes("same-cycle finish", 32'h7000, 2);
        check("same-cycle finish line_count", line_count, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
